button_debouncer: RTL
=====================

BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, meaning the number of consecutive equal synchronized samples required to accept a level change; legal range 2..65535.
REQ-002 clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 btn_in  input  1  raw asynchronous, bouncy push-button level; 1 = pressed.
REQ-005 btn_level  output  1  debounced button level, registered.
REQ-006 press_pulse  output  1  single-cycle strobe on each accepted press; drives the enable of the downstream binary counter.
REQ-007 release_pulse  output  1  single-cycle strobe on each accepted release.
REQ-008 press_cnt  output  8  running count of accepted presses, for debug and bench checking.

Function
REQ-009 btn_in SHALL pass through a two-flop synchronizer (sync1, sync2); only sync2 feeds the FSM.
REQ-010 FSM SHALL have exactly four states: IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT.
REQ-011 IDLE: sync2=1 -> PRESS_WAIT with stability counter cnt=1; otherwise remain in IDLE with cnt=0.
REQ-012 PRESS_WAIT: sync2=0 -> IDLE, cnt=0; sync2=1 and cnt=STABLE_CYCLES-1 -> PRESSED; otherwise cnt+1.
REQ-013 PRESSED: sync2=0 -> RELEASE_WAIT with cnt=1; otherwise remain with cnt=0.
REQ-014 RELEASE_WAIT: sync2=1 -> PRESSED, cnt=0; sync2=0 and cnt=STABLE_CYCLES-1 -> IDLE; otherwise cnt+1.
REQ-015 btn_level SHALL be 1 exactly while the state is PRESSED or RELEASE_WAIT.
REQ-016 press_pulse SHALL be 1 for exactly the one cycle following the PRESS_WAIT->PRESSED transition edge; release_pulse likewise for RELEASE_WAIT->IDLE.
REQ-017 If btn_in=1 at sampling edges n..n+STABLE_CYCLES-1, btn_level and press_pulse SHALL go high after edge n+STABLE_CYCLES+1; release latency SHALL be identical.
REQ-018 A run of fewer than STABLE_CYCLES equal samples SHALL produce no pulse and no btn_level change.
REQ-019 press_pulse and release_pulse SHALL never be high in the same cycle; two press_pulses SHALL always be separated by one release_pulse.
REQ-020 press_cnt SHALL increment by 1 in the cycle press_pulse is high, and wrap 255 -> 0 without a flag.
REQ-021 cnt width SHALL hold STABLE_CYCLES-1 without overflow; cnt SHALL never exceed STABLE_CYCLES-1.

Reset
REQ-022 While rst=1 at a rising edge: state=IDLE, cnt=0, sync1=sync2=0, btn_level=0, press_pulse=0, release_pulse=0, press_cnt=0.
REQ-023 rst SHALL take priority over every other event, including a transition on the same edge; no pulse is emitted on that edge.
REQ-024 After reset is released while btn_in is held high, the block SHALL treat it as a new press: press_pulse after STABLE_CYCLES+2 edges.
REQ-025 Reset SHALL NOT be synchronized or stretched internally; at least one clock edge with rst=1 is required.

Verification
Default setup: STABLE_CYCLES=4, 10 ns clock, rst held high for 2 edges.
REQ-026 Clean press: btn_in 0->1 sampled at edge 0 and held -> btn_level=1 and press_pulse=1 after edge 5; press_pulse=0 after edge 6; press_cnt=1.
REQ-027 Bounce rejection: btn_in high for 3 edges, low for 1, repeated 5 times -> press_pulse never 1, btn_level stays 0, press_cnt stays 0.
REQ-028 Clean release: from PRESSED, btn_in 1->0 held -> release_pulse=1 and btn_level=0 after edge 5 relative to the first low sample; release glitch of 2 samples returns to PRESSED with no pulse.
REQ-029 Wrap: 256 clean press/release pairs -> press_cnt counts to 255 then reads 0; exactly 256 press_pulses and 256 release_pulses observed.
REQ-030 Reset mid-operation: rst=1 at the edge PRESS_WAIT would enter PRESSED (cnt=3) -> all outputs 0 on that edge, no press_pulse; with btn_in still high after rst=0, press_pulse 6 edges later and press_cnt=1.
REQ-031 Downstream hookup: press_pulse drives BinaryCounter enable; 3 clean presses -> count advances by exactly 3.

Source files
------------

// File: rtl/button_debouncer.sv
// Push-button debouncer: two-flop synchronizer, four-state stability FSM with
// registered level and press/release strobes, and a press counter whose
// enable is the press strobe.

// Free-running binary counter advanced by a single-cycle enable strobe.
module binary_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] count
);

  // Count enable strobes; wraps silently at 2**W.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (en) begin
      count <= count + W'(1);
    end
  end

endmodule

module button_debouncer #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_in,
  output logic       btn_level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic [7:0] press_cnt
);

  // Stability counter only ever needs to reach STABLE_CYCLES-1.
  localparam int unsigned CNT_W = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             sync1;
  logic             sync2;

  // Bring the asynchronous button level into the clock domain.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments make sync2 take the previous sync1, which
    // is what forms the two-stage chain; blocking ones would collapse it.
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn_in;
      sync2 <= sync1;
    end
  end

  // Debounce FSM: a level change is accepted only after STABLE_CYCLES equal
  // synchronized samples; level and strobes are registered with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (sync2) begin
            state <= PRESS_WAIT;
            cnt   <= CNT_ONE;
          end else begin
            cnt <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!sync2) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state       <= PRESSED;
            cnt         <= '0;
            btn_level   <= 1'b1;
            press_pulse <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        PRESSED: begin
          if (!sync2) begin
            state <= RELEASE_WAIT;
            cnt   <= CNT_ONE;
          end else begin
            cnt <= '0;
          end
        end
        RELEASE_WAIT: begin
          if (sync2) begin
            state <= PRESSED;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state         <= IDLE;
            cnt           <= '0;
            btn_level     <= 1'b0;
            release_pulse <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state     <= IDLE;
          cnt       <= '0;
          btn_level <= 1'b0;
        end
      endcase
    end
  end

  // Press counter, enabled by the press strobe exactly as a downstream
  // consumer would see it.
  binary_counter #(
    .W (8)
  ) u_press_counter (
    .clk   (clk),
    .rst   (rst),
    .en    (press_pulse),
    .count (press_cnt)
  );

endmodule
